instr_encoder: RTL and testbench

- Inverse of the core's immediate/instruction field decode: packs RV32I fields plus a 32-bit immediate into a 32-bit instruction word.
- Used by the debug/program-injection path and by self-test generators to build instructions on the fly.
- Single-register pipeline stage with valid/ready on both sides, immediate range checking, and accepted/error statistics counters.

---
 rtl/instr_encoder.sv | 122 ++++++++++++
 tb/tb_instr_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_encoder                                                      |
// | Packs RV32I fields plus a 32-bit immediate into an instruction     |
// | word behind a one-deep valid/ready stage with statistics counters. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] acc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [2:0] c_FMT_I  = 3'd0;
  localparam logic [2:0] c_FMT_SH = 3'd1;
  localparam logic [2:0] c_FMT_S  = 3'd2;
  localparam logic [2:0] c_FMT_B  = 3'd3;
  localparam logic [2:0] c_FMT_U  = 3'd4;
  localparam logic [2:0] c_FMT_J  = 3'd5;
  localparam logic [2:0] c_FMT_R  = 3'd6;

  logic             r_out_valid;
  logic [31:0]      r_out_instr;
  logic             r_out_err;
  logic [CNT_W-1:0] r_acc_count;
  logic [CNT_W-1:0] r_err_count;

  logic        w_accept;
  logic [31:0] w_enc;
  logic        w_range_err;
  logic        w_err;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Field placement and per-format immediate range check.
  always_comb begin
    w_enc       = 32'h0;
    w_range_err = 1'b0;
    case (fmt)
      c_FMT_I: begin
        w_enc       = {imm[11:0], rs1, funct3, rd, opcode};
        w_range_err = (imm[31:11] != {21{imm[11]}});
      end
      c_FMT_SH: begin
        w_enc       = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        w_range_err = (imm[31:5] != 27'h0);
      end
      c_FMT_S: begin
        w_enc       = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_range_err = (imm[31:11] != {21{imm[11]}});
      end
      c_FMT_B: begin
        w_enc       = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      c_FMT_U: begin
        w_enc       = {imm[31:12], rd, opcode};
        w_range_err = (imm[11:0] != 12'h0);
      end
      c_FMT_J: begin
        w_enc       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      c_FMT_R: begin
        w_enc       = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        w_range_err = 1'b1;
      end
    endcase
  end

  assign w_err = w_range_err || (opcode[1:0] != 2'b11);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0;
      r_out_err   <= 1'b0;
      r_acc_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_err ? 32'h0 : w_enc;
        r_out_err   <= w_err;
        r_acc_count <= r_acc_count + 1'b1;
        if (w_err && (r_err_count != {CNT_W{1'b1}})) begin
          r_err_count <= r_err_count + 1'b1;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign acc_count = r_acc_count;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_encoder                                                   |
// | Directed scoreboard bench for instr_encoder (16-bit and 2-bit      |
// | counter instances driven in parallel).                             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_instr_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready, in_ready_s;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid, out_valid_s;
  logic        out_ready;
  logic [31:0] out_instr, out_instr_s;
  logic        out_err, out_err_s;
  logic [15:0] acc_count, err_count;
  logic [1:0]  acc_count_s, err_count_s;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_acc = 0;
  int   exp_err = 0;

  always #5 clk = ~clk;

  instr_encoder #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .acc_count(acc_count), .err_count(err_count)
  );

  instr_encoder #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s),
    .out_err(out_err_s), .acc_count(acc_count_s), .err_count(err_count_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Words leave the stage at the edge following a negedge with valid&&ready.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_word", out_instr, 32'h0);
        check("unexpected_word_valid", {31'h0, out_valid}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_instr", out_instr, e.instr);
        check("out_err", {31'h0, out_err}, {31'h0, e.err});
      end
    end
  end

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im,
                         input logic [31:0] ei, input logic ee);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
    q.push_back('{instr: ei, err: ee});
  endtask

  task automatic note_accept(input logic ee);
    exp_acc++;
    if (ee) exp_err++;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] ei, input logic ee);
    bit ok = 0;
    set_req(f, op, d, s1, s2, f3, f7, im, ei, ee);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'h0, 32'h1);
    else note_accept(ee);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_acc"}, {16'h0, acc_count}, exp_acc[31:0] & 32'hFFFF);
    check({tag, "_err"}, {16'h0, err_count}, exp_err[31:0] & 32'hFFFF);
    check({tag, "_acc_s"}, {30'h0, acc_count_s}, exp_acc[31:0] & 32'h3);
    check({tag, "_err_s"}, {30'h0, err_count_s}, (exp_err > 3) ? 32'd3 : exp_err[31:0]);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = 3'd0; opcode = 7'h0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_out_instr", out_instr, 32'h0);
    check_counts("rst");

    // addi x1, x0, -1
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    check("i_valid", {31'h0, out_valid}, 32'h1);
    check_counts("i");
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008, 32'h008000EF, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h0, 1'b1);
    idle();
    check_counts("u_err");
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h00000008, 32'h0020A423, 1'b0);
    send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0);
    idle();
    idle();

    // Backpressure: first word held while two more wait behind it.
    out_ready = 1'b0;
    send(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0, 32'h002081B3, 1'b0);
    set_req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h8, 32'h0020A423, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_hold_instr", out_instr, 32'h002081B3);
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_acc", {16'h0, acc_count}, exp_acc[31:0] & 32'hFFFF);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    note_accept(1'b0);
    set_req(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'h3, 32'h40335293, 1'b0);
    @(posedge clk); #1;
    note_accept(1'b0);
    in_valid = 1'b0;
    check("bp_valid", {31'h0, out_valid}, 32'h1);
    idle();
    idle();
    check_counts("bp");
    check("bp_drained", q.size(), 32'h0);

    // Error cases; the 2-bit instance saturates along the way.
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000003, 32'h0, 1'b1);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h0, 1'b1);
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000000, 32'h0, 1'b1);
    check_counts("err3");
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd1, 7'd0, 32'h00000020, 32'h0, 1'b1);
    send(3'd0, 7'h12, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000001, 32'h0, 1'b1);
    send(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0);
    idle();
    check_counts("sat");

    // Async reset while a word is held.
    out_ready = 1'b0;
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008, 32'h008000EF, 1'b0);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    exp_acc = 0;
    exp_err = 0;
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_instr", out_instr, 32'h0);
    check("arst_err", {31'h0, out_err}, 32'h0);
    check("arst_valid_s", {31'h0, out_valid_s}, 32'h0);
    check_counts("arst");
    @(negedge clk) reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("post_rst_valid", {31'h0, out_valid}, 32'h0);
    check("final_queue", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
